io_input_capture: RTL and testbench
===================================

IO_INPUT_CAPTURE -- requirements
Module: io_input_capture

Interface
REQ-001 SHALL have parameter NKEY, default 4, the number of push-button inputs.
REQ-002 SHALL have parameter NSW, default 10, the number of slide-switch inputs.
REQ-003 SHALL have parameter DB_CYCLES, default 4, the number of consecutive stable clk cycles needed to accept a new input level (range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: an asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port key_in, input, NKEY bits: raw asynchronous buttons, active-low (0 = pressed).
REQ-007 SHALL have port sw_in, input, NSW bits: raw asynchronous switches.
REQ-008 SHALL have port sel, input, 1 bit: I/O region select, driven by the addr[9] decode.
REQ-009 SHALL have port addr, input, 32 bits: the CPU byte address.
REQ-010 SHALL have port writedata, input, 32 bits: the CPU store data.
REQ-011 SHALL have port memwrite, input, 1 bit: the CPU store strobe.
REQ-012 SHALL have port readdata, output, 32 bits: the register read value, driven combinationally.
REQ-013 SHALL have port irq, output, 1 bit: the interrupt request; it exists only under IO_CAPTURE_IRQ_EN.

Function
REQ-014 SHALL pass each key_in and sw_in bit through a 2-flop synchronizer before any other logic uses it.
REQ-015 SHALL debounce each bit separately:
- A stable bit takes the synchronized level once that level has differed from it for DB_CYCLES consecutive cycles.
- Any cycle where the level matches the stable bit clears that bit's counter to 0.
REQ-016 SHALL make the counter width $clog2(DB_CYCLES+1) and SHALL NOT let the counter wrap.
REQ-017 SHALL set a sticky key_edge[i] bit when stable key i goes from 1 to 0 (a press).
REQ-018 SHALL set a sticky sw_edge[j] bit when stable switch j changes in either direction.
REQ-019 SHALL decode registers only when sel=1, using one-hot address bits:
- addr[4] (0x110): KEY stable level, read-only.
- addr[5] (0x120): SW stable level, read-only.
- addr[6] (0x140): EDGE register, {sw_edge in bits [NSW+15:16], key_edge in bits [NKEY-1:0]}, read and write-1-to-clear.
REQ-020 SHALL use the read priority addr[4] > addr[5] > addr[6], and SHALL read 0 when none of these bits is set or sel=0.
REQ-021 SHALL zero-extend all unused readdata bits.
REQ-022 SHALL clear each EDGE bit on a cycle with memwrite & sel & addr[6] when the matching writedata bit is 1, with the clear effective on the next clk edge.
REQ-023 SHALL let a set win over a clear for the same bit in the same cycle (simultaneous event), so the new edge is not lost.
REQ-024 SHALL ignore writes to the KEY and SW addresses.
REQ-025 SHALL give a latency of exactly 2 (sync) + DB_CYCLES + 1 cycles from a raw input change held steady to the stable-bit update.
REQ-026 SHALL make the EDGE bit visible in the same cycle as the stable-bit update.

Reset
REQ-027 SHALL, on reset=0 and asynchronously, set these to all 1s:
- the key synchronizer flops;
- the key stable bits.
REQ-028 SHALL, on reset=0 and asynchronously, clear these to 0:
- the switch synchronizer flops and switch stable bits;
- all debounce counters and all EDGE bits;
- the irq mask (when present) and irq.
REQ-029 SHALL NOT produce any edge from reset release itself; a switch held at 1 through reset sets sw_edge once it debounces after release.

Configuration
REQ-030 SHALL, when IO_CAPTURE_IRQ_EN is defined, add:
- an irq-mask register at addr[7] (0x180), same layout as EDGE, read/write;
- a registered irq = |(EDGE & mask), updated one cycle after EDGE or the mask changes.
REQ-031 SHALL, when IO_CAPTURE_IRQ_EN is undefined, omit the irq port and the mask register, and addr[7] SHALL read 0.

Structure
REQ-032 SHALL take the address-bit constants (IO_KEY_bit=4, IO_SW_bit=5, IO_EDGE_bit=6, IO_MASK_bit=7) and the EDGE field offsets from the shared package io_pkg.
REQ-033 SHALL use one sub-module, io_debounce: a 1-bit synchronizer plus debounce counter with parameters DB_CYCLES and reset value RST_VAL, instantiated NKEY+NSW times.

Verification
REQ-034 SHALL test key debounce: hold key_in[1]=0 from cycle 10 -> KEY read = 4'b1101 at cycle 10+2+4+1, and EDGE bit 1 = 1.
REQ-035 SHALL test bounce rejection: toggle sw_in[3] every 2 cycles for 20 cycles, then hold at 1 -> no SW change until 4 stable cycles, then one sw_edge[3] only.
REQ-036 SHALL test W1C: with EDGE=0x0004_0002, write 0x0000_0002 to 0x140 -> the next read returns 0x0004_0000.
REQ-037 SHALL test the simultaneous event: a press of key 0 debounces in the same cycle as a W1C of bit 0 -> key_edge[0] stays 1.
REQ-038 SHALL test async reset: assert reset=0 in the middle of a debounce -> KEY=4'hF, SW=0 and EDGE=0 immediately, with no edge after release.
REQ-039 SHALL test irq under IO_CAPTURE_IRQ_EN: write mask 0x1 to 0x180, press key 0 -> irq=1 one cycle after the EDGE bit sets; W1C -> irq=0 the next cycle.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped input-capture block: register
// address bits, EDGE field offsets and the register-select decode.
package io_pkg;

    localparam int IO_KEY_bit  = 4;
    localparam int IO_SW_bit   = 5;
    localparam int IO_EDGE_bit = 6;
    localparam int IO_MASK_bit = 7;

    localparam int EDGE_KEY_OFS = 0;
    localparam int EDGE_SW_OFS  = 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_KEY,
        REG_SW,
        REG_EDGE,
        REG_MASK
    } reg_sel_e;

    // hit = addr[IO_MASK_bit:IO_KEY_bit]; lower address bit wins
    function automatic reg_sel_e decode_reg(input logic sel, input logic [3:0] hit);
        if (!sel)        return REG_NONE;
        if (hit[0])      return REG_KEY;
        if (hit[1])      return REG_SW;
        if (hit[2])      return REG_EDGE;
        if (hit[3])      return REG_MASK;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/io_input_capture_if.sv
// CPU-side register bus of io_input_capture: select, address, store data,
// store strobe and combinational read data.
interface io_input_capture_if;

    logic        sel;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;

    modport master (output sel, output addr, output writedata, output memwrite,
                    input  readdata);

    modport slave  (input  sel, input  addr, input  writedata, input  memwrite,
                    output readdata);

endinterface

// File: rtl/io_input_capture_debounce.sv
// One input bit: 2-flop synchronizer followed by a saturating debounce
// counter; 'update' pulses in the cycle the stable level is about to flip.
module io_debounce #(
    parameter int   DB_CYCLES = 4,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic update
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        update   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES)) begin
            // counter has seen DB_CYCLES differing cycles: accept the level
            stable_d = sync2_q;
            cnt_d    = '0;
            update   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= RST_VAL;
            sync2_q  <= RST_VAL;
            stable_q <= RST_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/io_input_capture.sv
// Debounced push-button / slide-switch capture with sticky W1C edge flags.
// Optional irq mask and registered irq under `define IO_CAPTURE_IRQ_EN.
module io_input_capture
    import io_pkg::*;
#(
    parameter int NKEY      = 4,
    parameter int NSW       = 10,
    parameter int DB_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NKEY-1:0]     key_in,
    input  logic [NSW-1:0]      sw_in,
    io_input_capture_if.slave   bus
`ifdef IO_CAPTURE_IRQ_EN
    ,
    output logic                irq
`endif
);

    logic [NKEY-1:0] key_stable, key_upd;
    logic [NSW-1:0]  sw_stable,  sw_upd;

    for (genvar i = 0; i < NKEY; i++) begin : g_key
        io_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (key_in[i]),
            .stable (key_stable[i]),
            .update (key_upd[i])
        );
    end

    for (genvar j = 0; j < NSW; j++) begin : g_sw
        io_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_in[j]),
            .stable (sw_stable[j]),
            .update (sw_upd[j])
        );
    end

    reg_sel_e        rsel;
    logic            edge_wr;
    logic [NKEY-1:0] key_edge_q, key_edge_d;
    logic [NSW-1:0]  sw_edge_q,  sw_edge_d;
    logic [31:0]     edge_word;

    assign rsel    = decode_reg(bus.sel, bus.addr[IO_MASK_bit:IO_KEY_bit]);
    assign edge_wr = bus.memwrite & bus.sel & bus.addr[IO_EDGE_bit];

    // clear first, then OR in new edges so a same-cycle event survives the W1C
    always_comb begin
        key_edge_d = key_edge_q;
        sw_edge_d  = sw_edge_q;
        if (edge_wr) begin
            key_edge_d = key_edge_d & ~bus.writedata[EDGE_KEY_OFS +: NKEY];
            sw_edge_d  = sw_edge_d  & ~bus.writedata[EDGE_SW_OFS +: NSW];
        end
        key_edge_d = key_edge_d | (key_upd & key_stable);
        sw_edge_d  = sw_edge_d  | sw_upd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_edge_q <= '0;
            sw_edge_q  <= '0;
        end else begin
            key_edge_q <= key_edge_d;
            sw_edge_q  <= sw_edge_d;
        end
    end

    always_comb begin
        edge_word = '0;
        edge_word[EDGE_KEY_OFS +: NKEY] = key_edge_q;
        edge_word[EDGE_SW_OFS +: NSW]   = sw_edge_q;
    end

`ifdef IO_CAPTURE_IRQ_EN
    logic            mask_wr;
    logic [NKEY-1:0] key_mask_q, key_mask_d;
    logic [NSW-1:0]  sw_mask_q,  sw_mask_d;
    logic            irq_q, irq_d;
    logic [31:0]     mask_word;

    assign mask_wr = bus.memwrite & bus.sel & bus.addr[IO_MASK_bit];

    always_comb begin
        key_mask_d = key_mask_q;
        sw_mask_d  = sw_mask_q;
        if (mask_wr) begin
            key_mask_d = bus.writedata[EDGE_KEY_OFS +: NKEY];
            sw_mask_d  = bus.writedata[EDGE_SW_OFS +: NSW];
        end
        irq_d = |{key_edge_q & key_mask_q, sw_edge_q & sw_mask_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_mask_q <= '0;
            sw_mask_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            key_mask_q <= key_mask_d;
            sw_mask_q  <= sw_mask_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        mask_word = '0;
        mask_word[EDGE_KEY_OFS +: NKEY] = key_mask_q;
        mask_word[EDGE_SW_OFS +: NSW]   = sw_mask_q;
    end

    assign irq = irq_q;
`endif

    always_comb begin
        bus.readdata = '0;
        case (rsel)
            REG_KEY:  bus.readdata = 32'(key_stable);
            REG_SW:   bus.readdata = 32'(sw_stable);
            REG_EDGE: bus.readdata = edge_word;
`ifdef IO_CAPTURE_IRQ_EN
            REG_MASK: bus.readdata = mask_word;
`endif
            default:  bus.readdata = '0;
        endcase
    end

    logic unused_bus;
    assign unused_bus = ^{bus.addr, bus.writedata};

endmodule

// File: tb/tb_io_input_capture.sv
// Directed bench for io_input_capture: a sample-window model of the
// debounce plus literal expectations at key points of each scenario.
module tb_io_input_capture;

    localparam int NKEY = 4;
    localparam int NSW  = 10;
    localparam int DB   = 4;
    localparam int HD   = 16;
    localparam logic [31:0] VMASK = 32'h03FF_000F;

    logic            clk    = 1'b0;
    logic            reset  = 1'b1;
    logic [NKEY-1:0] key_in = '1;
    logic [NSW-1:0]  sw_in  = '0;
`ifdef IO_CAPTURE_IRQ_EN
    logic            irq;
`endif

    io_input_capture_if bus();

    io_input_capture #(.NKEY(NKEY), .NSW(NSW), .DB_CYCLES(DB)) dut (
        .clk    (clk),
        .reset  (reset),
        .key_in (key_in),
        .sw_in  (sw_in),
        .bus    (bus.slave)
`ifdef IO_CAPTURE_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a stable bit flips when the DB+1 raw samples taken 2..DB+2
    // edges ago all differ from it.
    logic [NKEY-1:0] m_key;
    logic [NSW-1:0]  m_sw;
    logic [31:0]     m_edge;
    logic [31:0]     m_mask;
    logic            m_irq;
    logic [NKEY-1:0] hk [HD];
    logic [NSW-1:0]  hs [HD];
    logic [31:0]     set_v;
    bit              all_diff;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_key  = '1;
            m_sw   = '0;
            m_edge = '0;
            m_mask = '0;
            m_irq  = 1'b0;
            for (int i = 0; i < HD; i++) begin
                hk[i] = '1;
                hs[i] = '0;
            end
        end else begin
            m_irq = |(m_edge & m_mask);
            for (int i = HD - 1; i > 0; i--) begin
                hk[i] = hk[i-1];
                hs[i] = hs[i-1];
            end
            hk[0] = key_in;
            hs[0] = sw_in;
            set_v = '0;
            for (int b = 0; b < NKEY; b++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= DB + 2; k++)
                    if (hk[k][b] == m_key[b]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_key[b]) set_v[b] = 1'b1;
                    m_key[b] = ~m_key[b];
                end
            end
            for (int b = 0; b < NSW; b++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= DB + 2; k++)
                    if (hs[k][b] == m_sw[b]) all_diff = 1'b0;
                if (all_diff) begin
                    set_v[16 + b] = 1'b1;
                    m_sw[b] = ~m_sw[b];
                end
            end
            if (bus.memwrite && bus.sel && bus.addr[6])
                m_edge = m_edge & ~bus.writedata;
            m_edge = m_edge | set_v;
`ifdef IO_CAPTURE_IRQ_EN
            if (bus.memwrite && bus.sel && bus.addr[7])
                m_mask = bus.writedata & VMASK;
`endif
        end
    end

    function automatic logic [31:0] exp_rd();
        if (!bus.sel)    return 32'h0;
        if (bus.addr[4]) return 32'(m_key);
        if (bus.addr[5]) return 32'(m_sw);
        if (bus.addr[6]) return m_edge;
`ifdef IO_CAPTURE_IRQ_EN
        if (bus.addr[7]) return m_mask;
`endif
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        chk("rd_vs_model", bus.readdata, exp_rd());
`ifdef IO_CAPTURE_IRQ_EN
        chk("irq_vs_model", 32'(irq), 32'(m_irq));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.sel      = 1'b1;
        bus.addr     = a;
        bus.memwrite = 1'b0;
        #1;
        chk(name, bus.readdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.sel       = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
        bus.memwrite  = 1'b1;
        @(posedge clk);
        #1;
        bus.memwrite  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bus.sel = 1'b0; bus.addr = '0; bus.writedata = '0; bus.memwrite = 1'b0;
        #2 reset = 1'b0;
        rd(32'h110, 32'h0000_000F, "reset_key");
        rd(32'h120, 32'h0000_0000, "reset_sw");
        rd(32'h140, 32'h0000_0000, "reset_edge");
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();

        // key 1 press: visible 2+DB+1 edges after the change
        key_in[1] = 1'b0;
        repeat (6) tick();
        rd(32'h110, 32'h0000_000F, "key_lat_early");
        tick();
        rd(32'h110, 32'h0000_000D, "key_lat");
        rd(32'h140, 32'h0000_0002, "key_edge1");

        // W1C, ignored writes, priority and unmapped reads
        sw_in[2] = 1'b1;
        repeat (10) tick();
        rd(32'h140, 32'h0004_0002, "edge_pre_w1c");
        rd(32'h120, 32'h0000_0004, "sw2_level");
        wr(32'h140, 32'h0000_0002);
        rd(32'h140, 32'h0004_0000, "w1c");
        wr(32'h110, 32'hFFFF_FFFF);
        wr(32'h120, 32'hFFFF_FFFF);
        rd(32'h140, 32'h0004_0000, "ro_write_edge");
        rd(32'h110, 32'h0000_000D, "ro_write_key");
        rd(32'h170, 32'h0000_000D, "read_priority");
        rd(32'h160, 32'h0000_0004, "read_priority_sw");
        rd(32'h100, 32'h0000_0000, "read_unmapped");
        bus.sel = 1'b0; bus.addr = 32'h110; #1;
        chk("read_nosel", bus.readdata, 32'h0);
`ifndef IO_CAPTURE_IRQ_EN
        rd(32'h180, 32'h0000_0000, "mask_absent");
`endif
        wr(32'h140, 32'hFFFF_FFFF);
        rd(32'h140, 32'h0000_0000, "w1c_all");

        // bounce on sw_in[3], then hold high
        for (int c = 0; c < 20; c++) begin
            sw_in[3] = ((c / 2) % 2) == 0;
            tick();
        end
        sw_in[3] = 1'b1;
        rd(32'h120, 32'h0000_0004, "bounce_rejected");
        repeat (6) tick();
        rd(32'h120, 32'h0000_0004, "bounce_hold_early");
        tick();
        rd(32'h120, 32'h0000_000C, "bounce_settled");
        rd(32'h140, 32'h0008_0000, "bounce_edge");
        repeat (12) tick();
        rd(32'h140, 32'h0008_0000, "bounce_single");

        // key 0 press debounces in the same cycle as a W1C of bit 0
        wr(32'h140, 32'hFFFF_FFFF);
        key_in[0] = 1'b0;
        repeat (6) tick();
        wr(32'h140, 32'h0000_0001);
        rd(32'h140, 32'h0000_0001, "simul_set_wins");
        rd(32'h110, 32'h0000_000C, "simul_key");

        // return to idle, then async reset mid-debounce
        key_in = '1;
        sw_in  = '0;
        repeat (12) tick();
        wr(32'h140, 32'hFFFF_FFFF);
        rd(32'h140, 32'h0000_0000, "idle_edge");
        key_in[2] = 1'b0;
        sw_in[5]  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rd(32'h110, 32'h0000_000F, "async_rst_key");
        rd(32'h120, 32'h0000_0000, "async_rst_sw");
        rd(32'h140, 32'h0000_0000, "async_rst_edge");
        key_in[2] = 1'b1;
        sw_in[5]  = 1'b0;
        sw_in[0]  = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        rd(32'h140, 32'h0000_0000, "no_edge_on_release");
        repeat (12) tick();
        rd(32'h140, 32'h0001_0000, "sw_held_through_reset");
        rd(32'h120, 32'h0000_0001, "sw0_level");
        rd(32'h110, 32'h0000_000F, "key_idle_after_reset");

`ifdef IO_CAPTURE_IRQ_EN
        wr(32'h140, 32'hFFFF_FFFF);
        wr(32'h180, 32'h0000_0001);
        rd(32'h180, 32'h0000_0001, "mask_rb");
        key_in[0] = 1'b0;
        repeat (7) tick();
        rd(32'h140, 32'h0000_0001, "irq_edge_set");
        chk("irq_lag", 32'(irq), 32'h0);
        tick();
        chk("irq_set", 32'(irq), 32'h1);
        wr(32'h140, 32'h0000_0001);
        rd(32'h140, 32'h0000_0000, "irq_w1c_edge");
        chk("irq_hold", 32'(irq), 32'h1);
        tick();
        chk("irq_clear", 32'(irq), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
